// File: rtl/sm_debouncer_pkg.sv
// Shared types and constants for the push-button / switch input conditioner.
package sm_debouncer_pkg;

  // Number of board input channels (BUTTON, SW, SLIDE_SW bits).
  localparam int unsigned SM_WIDTH = 4;

  // Board build: roughly 20 ms of stable input at 50 MHz.
  localparam int unsigned SM_DEBOUNCE_CYCLES = 1_000_000;

  // Short filter used when the block is built stand-alone.
  localparam int unsigned SM_DEBOUNCE_CYCLES_DEFAULT = 4;

  // What the stable-time counter does on the coming edge.
  typedef enum logic [1:0] {
    CNT_CLEAR  = 2'd0,  // synchronised input agrees with the clean level
    CNT_STEP   = 2'd1,  // mismatch run continues, keep counting
    CNT_ACCEPT = 2'd2   // mismatch run long enough, take the new level
  } cnt_act_e;

  // Counter width; at least one bit even for a one-cycle filter.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/sm_debounce_bit.sv
// One debounced channel: two-flop synchroniser, stable-time counter,
// clean level and single-cycle rise/fall pulses.
module sm_debounce_bit
  import sm_debouncer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = SM_DEBOUNCE_CYCLES_DEFAULT,
  parameter logic        RESET_VALUE     = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_in,
  output logic clean,
  output logic rise,
  output logic fall
);

  localparam int unsigned      CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_clean;
  logic             r_rise;
  logic             r_fall;
  logic [CNT_W-1:0] r_cnt;

  cnt_act_e         w_act;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_clean_nxt;
  logic             w_rise_nxt;
  logic             w_fall_nxt;

  // Bring the asynchronous pin into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= RESET_VALUE;
      r_sync2 <= RESET_VALUE;
    end else begin
      r_sync1 <= raw_in;
      r_sync2 <= r_sync1;
    end
  end

  // Filter state register: counter, accepted level and edge pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_clean <= RESET_VALUE;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_clean <= w_clean_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
    end
  end

  // Decide the counter action; agreement always wins over the terminal count.
  always_comb begin
    w_act = CNT_STEP;
    if (r_sync2 == r_clean) begin
      w_act = CNT_CLEAR;
    end else if (r_cnt == CNT_LAST) begin
      w_act = CNT_ACCEPT;
    end
  end

  // Next counter and level; the counter returns to zero on agreement and on accept.
  always_comb begin
    w_cnt_nxt   = '0;
    w_clean_nxt = r_clean;
    case (w_act)
      CNT_STEP:   w_cnt_nxt   = r_cnt + CNT_W'(1);
      CNT_ACCEPT: w_clean_nxt = r_sync2;
      default:    w_cnt_nxt   = '0;
    endcase
  end

  // Edge pulses follow the direction of the accepted change.
  always_comb begin
    w_rise_nxt = 1'b0;
    w_fall_nxt = 1'b0;
    if (w_act == CNT_ACCEPT) begin
      w_rise_nxt = r_sync2;
      w_fall_nxt = ~r_sync2;
    end
  end

  assign clean = r_clean;
  assign rise  = r_rise;
  assign fall  = r_fall;

endmodule

// File: rtl/sm_debouncer.sv
// Multi-channel input conditioner: one independent debounce channel per raw pin.
module sm_debouncer
  import sm_debouncer_pkg::*;
#(
  parameter int unsigned      WIDTH           = SM_WIDTH,
  parameter int unsigned      DEBOUNCE_CYCLES = SM_DEBOUNCE_CYCLES_DEFAULT,
  parameter logic [WIDTH-1:0] RESET_VALUE     = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] clean,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  // Channels share only clock, reset and filter length; bit i gets reset value bit i.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ch
    sm_debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_VALUE     (RESET_VALUE[gi])
    ) u_bit (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw_in (raw_in[gi]),
      .clean  (clean[gi]),
      .rise   (rise[gi]),
      .fall   (fall[gi])
    );
  end

endmodule

// File: tb/tb_sm_debouncer.sv
// Bench for sm_debouncer: a D=4 build and a D=1 build share one stimulus stream.
module tb_sm_debouncer;

  localparam int unsigned W   = 4;
  localparam int unsigned D_A = 4;
  localparam int unsigned D_B = 1;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] raw_in;
  logic [W-1:0] clean_a, rise_a, fall_a;
  logic [W-1:0] clean_b, rise_b, fall_b;

  int n_vec = 0;
  int n_mis = 0;
  bit chk_en = 1'b0;

  sm_debouncer #(.WIDTH(W), .DEBOUNCE_CYCLES(D_A), .RESET_VALUE(4'hF)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .raw_in(raw_in),
    .clean(clean_a), .rise(rise_a), .fall(fall_a)
  );

  sm_debouncer #(.WIDTH(W), .DEBOUNCE_CYCLES(D_B), .RESET_VALUE(4'hF)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .raw_in(raw_in),
    .clean(clean_b), .rise(rise_b), .fall(fall_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %b, want %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a channel takes a new level once the last D synchronised samples
  // all disagree with its current level. Synchronised sample = raw two edges ago.
  logic [W-1:0] m_s1[2], m_s2[2], m_clean[2], m_rise[2], m_fall[2];
  logic [W-1:0] m_win[2][4];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        m_s1[b]    = 4'hF;
        m_s2[b]    = 4'hF;
        m_clean[b] = 4'hF;
        m_rise[b]  = 4'h0;
        m_fall[b]  = 4'h0;
        for (int j = 0; j < 4; j++) m_win[b][j] = 4'hF;
      end
    end else begin
      for (int b = 0; b < 2; b++) begin
        int d;
        d = (b == 0) ? int'(D_A) : int'(D_B);
        for (int j = 3; j > 0; j--) m_win[b][j] = m_win[b][j-1];
        m_win[b][0] = m_s2[b];
        m_rise[b] = 4'h0;
        m_fall[b] = 4'h0;
        for (int c = 0; c < int'(W); c++) begin
          bit all_new;
          all_new = 1'b1;
          for (int j = 0; j < d; j++)
            if (m_win[b][j][c] == m_clean[b][c]) all_new = 1'b0;
          if (all_new) begin
            m_clean[b][c] = ~m_clean[b][c];
            if (m_clean[b][c]) m_rise[b][c] = 1'b1;
            else               m_fall[b][c] = 1'b1;
          end
        end
        m_s2[b] = m_s1[b];
        m_s1[b] = raw_in;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_clean_d4", clean_a, m_clean[0]);
      check("model_rise_d4",  rise_a,  m_rise[0]);
      check("model_fall_d4",  fall_a,  m_fall[0]);
      check("model_clean_d1", clean_b, m_clean[1]);
      check("model_rise_d1",  rise_b,  m_rise[1]);
      check("model_fall_d1",  fall_b,  m_fall[1]);
      check("excl_d4", rise_a & fall_a, 4'h0);
      check("excl_d1", rise_b & fall_b, 4'h0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stable change sampled at E0: D=1 updates at E2, D=4 at E5, pulses last one cycle.
  task automatic edge_test(input string tag, input logic [W-1:0] nraw, input logic [W-1:0] old_c,
                           input logic [W-1:0] exp_c, input logic [W-1:0] er, input logic [W-1:0] ef);
    @(negedge clk);
    raw_in = nraw;
    tick();                                           // E0
    tick();                                           // E1
    check($sformatf("%s_d1_e1_clean", tag), clean_b, old_c);
    tick();                                           // E2
    check($sformatf("%s_d1_e2_clean", tag), clean_b, exp_c);
    tick(); tick();                                   // E4
    check($sformatf("%s_e4_clean", tag), clean_a, old_c);
    tick();                                           // E5
    check($sformatf("%s_e5_clean", tag), clean_a, exp_c);
    check($sformatf("%s_e5_rise", tag), rise_a, er);
    check($sformatf("%s_e5_fall", tag), fall_a, ef);
    tick();                                           // E6
    check($sformatf("%s_e6_pulse", tag), rise_a | fall_a, 4'h0);
  endtask

  initial begin
    logic [W-1:0] seen;
    logic [W-1:0] bounce [4];
    bounce[0] = 4'b0000; bounce[1] = 4'b0100; bounce[2] = 4'b0000; bounce[3] = 4'b0100;

    // Reset with inputs low: outputs at reset value.
    rst_n  = 1'b0;
    raw_in = 4'b0000;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    #1;
    check("rst_clean_d4", clean_a, 4'hF);
    check("rst_rise_d4",  rise_a,  4'h0);
    check("rst_fall_d4",  fall_a,  4'h0);
    check("rst_clean_d1", clean_b, 4'hF);

    // Release: no pulse at release, then the low inputs are accepted on every channel.
    @(negedge clk);
    rst_n = 1'b1;
    tick();                                           // E0
    check("rel_e0_pulse", rise_a | fall_a, 4'h0);
    tick(); tick();                                   // E2
    check("rel_d1_e2_clean", clean_b, 4'h0);
    check("rel_d1_e2_fall",  fall_b,  4'hF);
    tick(); tick();                                   // E4
    check("rel_e4_clean", clean_a, 4'hF);
    tick();                                           // E5
    check("rel_e5_clean", clean_a, 4'h0);
    check("rel_e5_fall",  fall_a,  4'hF);
    tick();
    check("rel_e6_fall",  fall_a,  4'h0);

    // Single-channel edges, other channels untouched.
    edge_test("rise0", 4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0000);
    edge_test("fall0", 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
    edge_test("set1",  4'b0010, 4'b0000, 4'b0010, 4'b0010, 4'b0000);

    // Glitch of three cycles on channel 1 is rejected.
    @(negedge clk); raw_in = 4'b0000;
    repeat (3) @(posedge clk);
    @(negedge clk); raw_in = 4'b0010;
    seen = 4'h0;
    repeat (8) begin
      tick();
      seen = seen | rise_a | fall_a;
    end
    check("glitch3_clean", clean_a, 4'b0010);
    check("glitch3_pulse", seen, 4'h0);

    // Four low cycles on channel 1 are accepted, then the return high is too.
    @(negedge clk); raw_in = 4'b0000;
    repeat (4) @(posedge clk);                        // E0..E3
    @(negedge clk); raw_in = 4'b0010;
    tick();                                           // E4
    check("low4_e4_clean", clean_a, 4'b0010);
    tick();                                           // E5
    check("low4_e5_clean", clean_a, 4'b0000);
    check("low4_e5_fall",  fall_a,  4'b0010);
    repeat (3) tick();                                // E8
    check("low4_e8_clean", clean_a, 4'b0000);
    tick();                                           // E9
    check("low4_e9_clean", clean_a, 4'b0010);
    check("low4_e9_rise",  rise_a,  4'b0010);

    // Channel 1 falls while channel 2 rises on the same edge.
    edge_test("swap12", 4'b0100, 4'b0010, 4'b0100, 4'b0100, 4'b0010);

    // Bounce on channel 2: single fall, five edges after the last transition is sampled.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); raw_in = bounce[k];
    end
    @(negedge clk); raw_in = 4'b0000;
    tick();                                           // E0
    seen = 4'h0;
    repeat (4) begin
      tick();
      seen = seen | rise_a | fall_a;
    end
    check("bounce_e4_clean", clean_a, 4'b0100);
    check("bounce_early_pulse", seen, 4'h0);
    tick();                                           // E5
    check("bounce_e5_clean", clean_a, 4'b0000);
    check("bounce_e5_fall",  fall_a,  4'b0100);

    // Channels 0 and 3 change in opposite directions together.
    edge_test("set3", 4'b1000, 4'b0000, 4'b1000, 4'b1000, 4'b0000);
    edge_test("sim03", 4'b0001, 4'b1000, 4'b0001, 4'b0001, 4'b1000);

    // Reset in the middle of a count discards the pending change.
    @(negedge clk); raw_in = 4'b0000;
    repeat (4) tick();                                // E0..E3, count at 2
    check("mid_e3_clean", clean_a, 4'b0001);
    rst_n = 1'b0;
    #1;
    check("mid_rst_clean", clean_a, 4'hF);
    check("mid_rst_pulse", rise_a | fall_a, 4'h0);
    @(negedge clk); rst_n = 1'b1;
    tick();                                           // E0
    seen = 4'h0;
    repeat (4) begin
      tick();
      seen = seen | rise_a | fall_a;
    end
    check("mid_e4_clean", clean_a, 4'hF);
    check("mid_early_pulse", seen, 4'h0);
    tick();                                           // E5
    check("mid_e5_clean", clean_a, 4'h0);
    check("mid_e5_fall",  fall_a,  4'hF);
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
